vga_rx_decoder: RTL

//  Receive-side counterpart of the VGA game output: samples hsync/vsync/rgb at pixel

---
 rtl/vga_rx_decoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_decoder.sv
// Pixel-rate VGA receive monitor: recovers active coordinates, verifies line/frame
// timing and reports lock. Define FRAME_SUM_EN to add a per-frame pixel checksum.
module vga_rx_decoder #(
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_ACT_START = 144,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned V_ACT_START = 34,
   parameter int unsigned V_ACTIVE    = 480
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [2:0]  i_rgb,
   output logic        o_locked,
   output logic        o_de,
   output logic [9:0]  o_hpos,
   output logic [9:0]  o_vpos,
   output logic [2:0]  o_pixel,
   output logic        o_frame_start,
   output logic        o_err,
`ifdef FRAME_SUM_EN
   output logic [21:0] o_frame_sum,
   output logic        o_sum_valid,
`endif
   output logic [7:0]  o_err_cnt
);
   localparam int unsigned CW = 10;
   localparam int unsigned PW = 3;
   localparam int unsigned EW = 8;

   typedef enum logic [1:0] {ACQ_H, ACQ_V, CHECK, LOCKED} state_e;

   state_e          state_q, state_d;
   logic            hs_q, vs_q;
   logic            v_pend_q, v_pend_d;
   logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic            locked_q, locked_d;
   logic            de_q, de_d;
   logic [CW-1:0]   hpos_q, hpos_d, vpos_q, vpos_d;
   logic [PW-1:0]   pixel_q, pixel_d;
   logic            fs_q, fs_d;
   logic            err_q, err_d;
   logic [EW-1:0]   err_cnt_q, err_cnt_d;
   logic            hs_fall, hs_rise, vs_fall, vload;
   logic            hviol, vviol, viol, in_win;

`ifdef FRAME_SUM_EN
   localparam int unsigned SW = 22;
   logic [SW-1:0]   acc_q, acc_d, sum_q, sum_d;
   logic            sv_q, sv_d;
`endif

   // Edge detection, counters, timing checks, FSM and output staging.
   always_comb begin
      state_d   = state_q;
      v_pend_d  = v_pend_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      err_cnt_d = err_cnt_q;
      hpos_d    = '0;
      vpos_d    = '0;
      pixel_d   = '0;

      hs_fall = ~i_hsync & hs_q;
      hs_rise = i_hsync & ~hs_q;
      vs_fall = ~i_vsync & vs_q;
      vload   = hs_fall & (v_pend_q | vs_fall);

      // Counters saturate at their last legal value; the timing check fires there.
      if (hs_fall)
         hcnt_d = '0;
      else if (hcnt_q != CW'(H_TOTAL - 1))
         hcnt_d = hcnt_q + CW'(1);

      if (vload) begin
         vcnt_d   = '0;
         v_pend_d = 1'b0;
      end else begin
         if (hs_fall && vcnt_q != CW'(V_TOTAL - 1))
            vcnt_d = vcnt_q + CW'(1);
         if (vs_fall)
            v_pend_d = 1'b1;
      end

      hviol = (hs_fall != (hcnt_q == CW'(H_TOTAL - 1))) |
              (hs_rise & (hcnt_q != CW'(H_SYNC - 1)));
      vviol = (vload & (vcnt_q != CW'(V_TOTAL - 1))) |
              (hs_fall & ~vload & (vcnt_q == CW'(V_TOTAL - 1)));
      viol  = ((state_q != ACQ_H) & hviol) |
              (((state_q == CHECK) | (state_q == LOCKED)) & vviol);

      if (viol)
         state_d = ACQ_H;
      else begin
         case (state_q)
            ACQ_H:   if (hs_fall) state_d = ACQ_V;
            ACQ_V:   if (vload)   state_d = CHECK;
            CHECK:   if (vload)   state_d = LOCKED;
            default: state_d = state_q;
         endcase
      end

      in_win = (hcnt_d >= CW'(H_ACT_START)) && (hcnt_d < CW'(H_ACT_START + H_ACTIVE)) &&
               (vcnt_d >= CW'(V_ACT_START)) && (vcnt_d < CW'(V_ACT_START + V_ACTIVE));
      de_d   = (state_q == LOCKED) && in_win;
      if (de_d) begin
         hpos_d  = hcnt_d - CW'(H_ACT_START);
         vpos_d  = vcnt_d - CW'(V_ACT_START);
         pixel_d = i_rgb;
      end

      locked_d = (state_d == LOCKED);
      fs_d     = (state_q == LOCKED) & vload & ~viol;
      err_d    = viol;
      if (viol && err_cnt_q != '1)
         err_cnt_d = err_cnt_q + EW'(1);

`ifdef FRAME_SUM_EN
      acc_d = acc_q;
      sum_d = sum_q;
      sv_d  = fs_d;
      if (viol)
         acc_d = '0;
      else if (fs_d) begin
         sum_d = acc_q;
         acc_d = '0;
      end else if (de_q)
         acc_d = acc_q + SW'(pixel_q);
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ACQ_H;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         v_pend_q  <= 1'b0;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         locked_q  <= 1'b0;
         de_q      <= 1'b0;
         hpos_q    <= '0;
         vpos_q    <= '0;
         pixel_q   <= '0;
         fs_q      <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
`ifdef FRAME_SUM_EN
         acc_q     <= '0;
         sum_q     <= '0;
         sv_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         hs_q      <= i_hsync;
         vs_q      <= i_vsync;
         v_pend_q  <= v_pend_d;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         locked_q  <= locked_d;
         de_q      <= de_d;
         hpos_q    <= hpos_d;
         vpos_q    <= vpos_d;
         pixel_q   <= pixel_d;
         fs_q      <= fs_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
`ifdef FRAME_SUM_EN
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         sv_q      <= sv_d;
`endif
      end
   end

   assign o_locked      = locked_q;
   assign o_de          = de_q;
   assign o_hpos        = hpos_q;
   assign o_vpos        = vpos_q;
   assign o_pixel       = pixel_q;
   assign o_frame_start = fs_q;
   assign o_err         = err_q;
   assign o_err_cnt     = err_cnt_q;
`ifdef FRAME_SUM_EN
   assign o_frame_sum   = sum_q;
   assign o_sum_valid   = sv_q;
`endif

endmodule
